// File: rtl/hazard_pkg.sv
// Shared types and constants for the execute-stage hazard/forwarding controller.
package hazard_pkg;

    localparam int unsigned RW    = 5;
    localparam int unsigned CNT_W = 16;
    localparam logic [RW-1:0] XZR = RW'(31);

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rn;
        logic [RW-1:0] rm;
        logic          uses_rm;
        logic [RW-1:0] rd;
        logic          regWrite;
        logic          memRead;
    } stage_rec_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_t;

    localparam stage_rec_t BUBBLE = '0;

    // A stage can supply a forwarded value only if it really writes a non-zero register.
    function automatic logic rec_writes(input stage_rec_t r);
        return r.valid & r.regWrite & (r.rd != XZR);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one ALU source: compares it against the MEM and WB destinations.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [RW-1:0] src,
    input  logic          src_used,
    input  logic          m_wr,
    input  logic [RW-1:0] m_rd,
    input  logic          w_wr,
    input  logic [RW-1:0] w_rd,
    output logic [1:0]    sel_c
);

    // MEM is the younger producer, so it takes priority over WB.
    always_comb begin
        sel_c = FWD_REG;
        if (src_used && w_wr && (w_rd == src)) sel_c = FWD_WB;
        if (src_used && m_wr && (m_rd == src)) sel_c = FWD_MEM;
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: shadow E/M/W records, forwarding selects,
// load-use stall, taken-branch flush and saturating event counters.
module ex_hazard_ctrl
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RW-1:0]    id_rn,
    input  logic [RW-1:0]    id_rm,
    input  logic             id_uses_rm,
    input  logic [RW-1:0]    id_rd,
    input  logic             id_regWrite,
    input  logic             id_memRead,
    input  logic             m_branch_taken,
    output logic             stall_F,
    output logic             stall_D,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_M,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    stage_rec_t e_q, m_q, w_q;
    stage_rec_t id_rec;
    hz_state_t  state_q, state_d;
    logic       lu;
    logic       unused_w;

    assign id_rec = '{valid: id_valid, rn: id_rn, rm: id_rm, uses_rm: id_uses_rm,
                      rd: id_rd, regWrite: id_regWrite, memRead: id_memRead};

    // Only the destination side of the WB record feeds any decision.
    assign unused_w = ^{w_q.rn, w_q.rm, w_q.uses_rm, w_q.memRead};

    assign lu = id_valid & e_q.valid & e_q.memRead & (e_q.rd != XZR)
              & ((e_q.rd == id_rn) | (id_uses_rm & (e_q.rd == id_rm)));

    fwd_sel u_fwd_a (
        .src      (e_q.rn),
        .src_used (1'b1),
        .m_wr     (rec_writes(m_q)),
        .m_rd     (m_q.rd),
        .w_wr     (rec_writes(w_q)),
        .w_rd     (w_q.rd),
        .sel_c    (fwdA)
    );

    fwd_sel u_fwd_b (
        .src      (e_q.rm),
        .src_used (e_q.uses_rm),
        .m_wr     (rec_writes(m_q)),
        .m_rd     (m_q.rd),
        .w_wr     (rec_writes(w_q)),
        .w_rd     (w_q.rd),
        .sel_c    (fwdB)
    );

    // Outputs are gated by reset so they read 0 the moment reset asserts.
    always_comb begin
        state_d = RUN;
        stall_F = 1'b0;
        stall_D = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_M = 1'b0;
        if (reset) begin
            if (m_branch_taken) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
                flush_M = 1'b1;
            end else if (state_q == RUN && lu) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
                state_d = STALL;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q <= BUBBLE;
            m_q <= BUBBLE;
            w_q <= BUBBLE;
        end else begin
            e_q <= flush_E ? BUBBLE : id_rec;
            m_q <= flush_M ? BUBBLE : e_q;
            w_q <= m_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_D && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (m_branch_taken && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: per-cycle reference model plus directed literal checks.
module tb_ex_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rn = '0, id_rm = '0, id_rd = '0;
    logic        id_uses_rm = 1'b0, id_regWrite = 1'b0, id_memRead = 1'b0;
    logic        m_branch_taken = 1'b0;
    logic        stall_F, stall_D, flush_D, flush_E, flush_M;
    logic [1:0]  fwdA, fwdB;
    logic [15:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    ex_hazard_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rm(id_uses_rm), .id_rd(id_rd), .id_regWrite(id_regWrite),
        .id_memRead(id_memRead), .m_branch_taken(m_branch_taken),
        .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
        .flush_M(flush_M), .fwdA(fwdA), .fwdB(fwdB),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: an in-flight list of instructions (index 0=E, 1=M, 2=W).
    typedef struct {
        bit v; int rn; int rm; bit u; int rd; bit wr; bit ld;
    } instr_t;

    instr_t pipe [3];
    bit     prev_stalled;
    int     m_scnt, m_fcnt;

    function automatic instr_t nothing();
        instr_t r;
        r = '{v: 0, rn: 0, rm: 0, u: 0, rd: 0, wr: 0, ld: 0};
        return r;
    endfunction

    function automatic bit produces(instr_t r, int src);
        return r.v && r.wr && r.rd != 31 && r.rd == src;
    endfunction

    function automatic int model_fwd(int src, bit used);
        if (!used) return 0;
        if (produces(pipe[1], src)) return 2;
        if (produces(pipe[2], src)) return 1;
        return 0;
    endfunction

    function automatic bit model_stall();
        bit needs;
        needs = id_valid && pipe[0].v && pipe[0].ld && pipe[0].rd != 31 &&
                (pipe[0].rd == int'(id_rn) || (id_uses_rm && pipe[0].rd == int'(id_rm)));
        return reset && !m_branch_taken && needs && !prev_stalled;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) pipe[i] = nothing();
            prev_stalled = 0;
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            bit st;
            instr_t dec;
            st = model_stall();
            dec = '{v: id_valid, rn: int'(id_rn), rm: int'(id_rm), u: id_uses_rm,
                    rd: int'(id_rd), wr: id_regWrite, ld: id_memRead};
            pipe[2] = pipe[1];
            pipe[1] = m_branch_taken ? nothing() : pipe[0];
            pipe[0] = (m_branch_taken || st) ? nothing() : dec;
            if (st && m_scnt < 65535) m_scnt++;
            if (m_branch_taken && m_fcnt < 65535) m_fcnt++;
            prev_stalled = st;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle: compare all outputs against the model.
    always @(negedge clk) begin
        bit st, br;
        st = model_stall();
        br = reset && m_branch_taken;
        check("m_stall_F", int'(stall_F), int'(st));
        check("m_stall_D", int'(stall_D), int'(st));
        check("m_flush_D", int'(flush_D), int'(br));
        check("m_flush_E", int'(flush_E), int'(br || st));
        check("m_flush_M", int'(flush_M), int'(br));
        check("m_fwdA", int'(fwdA), reset ? model_fwd(pipe[0].rn, 1) : 0);
        check("m_fwdB", int'(fwdB), reset ? model_fwd(pipe[0].rm, pipe[0].u) : 0);
        check("m_stall_cnt", int'(stall_cnt), m_scnt);
        check("m_flush_cnt", int'(flush_cnt), m_fcnt);
    end

    task automatic drive(input bit v, input int rn, input int rm, input bit u,
                         input int rd, input bit wr, input bit ld, input bit br);
        id_valid       = v;
        id_rn          = 5'(rn);
        id_rm          = 5'(rm);
        id_uses_rm     = u;
        id_rd          = 5'(rd);
        id_regWrite    = wr;
        id_memRead     = ld;
        m_branch_taken = br;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        nop();
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall_D", int'(stall_D), 0);
        check("rst_fwdA", int'(fwdA), 0);
        check("rst_stall_cnt", int'(stall_cnt), 0);
        reset = 1'b1;
        tick();

        // 1: ADD X1,X2,X3 ; SUB X4,X1,X5 -> EX/MEM forward on A
        drive(1, 2, 3, 1, 1, 1, 0, 0); tick();
        drive(1, 1, 5, 1, 4, 1, 0, 0); tick();
        nop();
        @(negedge clk);
        check("t1_fwdA", int'(fwdA), 2);
        check("t1_stall_D", int'(stall_D), 0);
        tick(); tick(); tick();

        // 2: ADD X1 ; AND X8,X9,X10 ; ORR X6,X7,X1 -> MEM/WB forward on B
        drive(1, 2, 3, 1, 1, 1, 0, 0); tick();
        drive(1, 9, 10, 1, 8, 1, 0, 0); tick();
        drive(1, 7, 1, 1, 6, 1, 0, 0); tick();
        nop();
        @(negedge clk);
        check("t2_fwdB", int'(fwdB), 1);
        check("t2_fwdA", int'(fwdA), 0);
        tick(); tick(); tick();

        // 3: LDUR X9,[X0] ; ADD X10,X9,X9 -> one stall, then WB forward on both
        drive(1, 0, 0, 0, 9, 1, 1, 0); tick();
        drive(1, 9, 9, 1, 10, 1, 0, 0);
        @(negedge clk);
        check("t3_stall_F", int'(stall_F), 1);
        check("t3_stall_D", int'(stall_D), 1);
        check("t3_flush_E", int'(flush_E), 1);
        tick();
        @(negedge clk);
        check("t3_no_second_stall", int'(stall_D), 0);
        tick();
        nop();
        @(negedge clk);
        check("t3_fwdA", int'(fwdA), 1);
        check("t3_fwdB", int'(fwdB), 1);
        check("t3_stall_cnt", int'(stall_cnt), 1);
        tick(); tick(); tick();

        // 4: load-use together with a taken branch -> flush wins
        drive(1, 0, 0, 0, 2, 1, 1, 0); tick();
        drive(1, 2, 0, 0, 3, 1, 0, 1);
        @(negedge clk);
        check("t4_flush_D", int'(flush_D), 1);
        check("t4_flush_E", int'(flush_E), 1);
        check("t4_flush_M", int'(flush_M), 1);
        check("t4_stall_F", int'(stall_F), 0);
        tick();
        nop();
        @(negedge clk);
        check("t4_flush_cnt", int'(flush_cnt), 1);
        check("t4_stall_cnt", int'(stall_cnt), 1);
        tick(); tick(); tick();

        // 5: XZR never forwards and never stalls
        drive(1, 2, 3, 1, 31, 1, 0, 0); tick();
        drive(1, 31, 5, 1, 4, 1, 0, 0); tick();
        nop();
        @(negedge clk);
        check("t5_fwdA_xzr", int'(fwdA), 0);
        tick(); tick();
        drive(1, 0, 0, 0, 31, 1, 1, 0); tick();
        drive(1, 31, 31, 1, 4, 1, 0, 0);
        @(negedge clk);
        check("t5_no_stall_xzr", int'(stall_F), 0);
        tick();
        nop(); tick(); tick(); tick();

        // 6: reset during the bubble cycle of a stall
        drive(1, 0, 0, 0, 9, 1, 1, 0); tick();
        drive(1, 9, 9, 1, 10, 1, 0, 0); tick();
        drive(1, 9, 9, 1, 10, 1, 0, 1);
        reset = 1'b0;
        #1;
        check("t6_rst_stall_D", int'(stall_D), 0);
        check("t6_rst_flush_D", int'(flush_D), 0);
        check("t6_rst_flush_M", int'(flush_M), 0);
        check("t6_rst_stall_cnt", int'(stall_cnt), 0);
        check("t6_rst_flush_cnt", int'(flush_cnt), 0);
        nop();
        tick(); tick();
        reset = 1'b1;
        @(negedge clk);
        check("t6_fwdA", int'(fwdA), 0);
        check("t6_fwdB", int'(fwdB), 0);
        check("t6_stall_cnt", int'(stall_cnt), 0);
        check("t6_flush_cnt", int'(flush_cnt), 0);
        tick();
        // Back in RUN: a fresh load-use stalls again
        drive(1, 0, 0, 0, 7, 1, 1, 0); tick();
        drive(1, 3, 7, 1, 8, 1, 0, 0);
        @(negedge clk);
        check("t6_run_stall", int'(stall_D), 1);
        tick();
        @(negedge clk);
        tick();
        nop(); tick(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
